// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction constants and the instruction-memory loader state
// encoding, which the debug unit also uses to decode o_busy / o_load_done.
package mips_pkg;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IMEM_IDLE  = 2'd0,
        IMEM_CLEAR = 2'd1,
        IMEM_LOAD  = 2'd2,
        IMEM_DONE  = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Collects four serial bytes into one 32-bit word, honouring the configured byte order.
// word_valid_o pulses combinationally with the 4th accepted byte.
module imem_byte_packer #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] asm_q;
    logic [23:0] asm_d;

    // Big-endian shifts new bytes in at the bottom, little-endian at the top.
    always_comb begin
        asm_d = asm_q;
        if (BIG_ENDIAN) begin
            asm_d  = {asm_q[15:0], byte_i};
            word_o = {asm_q, byte_i};
        end else begin
            asm_d  = {byte_i, asm_q[23:8]};
            word_o = {byte_i, asm_q};
        end
    end

    assign word_valid_o = accept_i && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= 2'd0;
            asm_q <= 24'd0;
        end else if (accept_i) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with combinational fetch read and a byte-serial clear-then-load port.
// Loading stops on the halt word (which is stored) or when every word has been written.
module imem_loadable
    import mips_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       i_pc,
    output logic [31:0]       o_instr,
    input  logic              i_load_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_full,
    output logic [ADDR_W:0]   o_word_count
);

    // state      | meaning
    // IMEM_IDLE  | no load since reset; fetch reads the array
    // IMEM_CLEAR | writing NOP to every word, one per cycle
    // IMEM_LOAD  | accepting bytes, writing packed words
    // IMEM_DONE  | load finished (halt word or memory full)

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    imem_state_e       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   word_count_q;
    logic              busy_q;
    logic              ready_q;
    logic              done_q;
    logic              full_q;

    logic [31:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [31:0]       mem_wdata;

    logic              accept;
    logic              word_valid;
    logic [31:0]       packed_word;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_pc;

    // A start pulse always wins over a byte arriving in the same cycle.
    assign accept = i_byte_valid && ready_q && !i_load_start;

    imem_byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (i_load_start),
        .accept_i     (accept),
        .byte_i       (i_byte),
        .word_valid_o (word_valid),
        .word_o       (packed_word)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = NOP_WORD;
        if (!reset && !i_load_start) begin
            if (state_q == IMEM_CLEAR) begin
                mem_we = 1'b1;
            end else if (word_valid) begin
                mem_we    = 1'b1;
                mem_wdata = packed_word;
            end
        end
    end

    // Synchronous write, asynchronous read: maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IMEM_IDLE;
            ptr_q        <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else if (i_load_start) begin
            state_q      <= IMEM_CLEAR;
            ptr_q        <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b1;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            case (state_q)
                IMEM_CLEAR: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= IMEM_LOAD;
                        ready_q <= 1'b1;
                    end
                end
                IMEM_LOAD: begin
                    if (word_valid) begin
                        ptr_q        <= ptr_q + ADDR_W'(1);
                        word_count_q <= word_count_q + (ADDR_W + 1)'(1);
                        if (packed_word == HALT_WORD) begin
                            state_q <= IMEM_DONE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (word_count_q == LAST_COUNT) begin
                            state_q <= IMEM_DONE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                            full_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_addr   = i_pc[ADDR_W+1:2];
    assign unused_pc = ^{i_pc[31:ADDR_W+2], i_pc[1:0]};

    assign o_instr      = busy_q ? NOP_WORD : mem_q[rd_addr];
    assign o_byte_ready = ready_q;
    assign o_busy       = busy_q;
    assign o_load_done  = done_q;
    assign o_full       = full_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a big-endian 8-word instance and a little-endian 4-word instance,
// each loaded with directed and random images and compared against a word-level image model.
module tb_imem_loadable;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ld_start;
    logic [1:0]  bvalid;
    logic [7:0]  bdata0, bdata1;
    logic [31:0] pc0, pc1;
    wire  [31:0] instr0, instr1;
    wire  [1:0]  rdy, bsy, dn, fl;
    wire  [3:0]  wc0;
    wire  [2:0]  wc1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [2][8];
    int          exp_wc   [2];
    bit          exp_full [2];
    bit          exp_done [2];
    int          exp_used [2];
    logic [7:0]  stream [$];

    always #5 clk = ~clk;

    imem_loadable #(.ADDR_W(3), .BIG_ENDIAN(1'b1), .HALT_WORD(32'hFFFF_FFFF)) u0 (
        .clk(clk), .reset(rst), .i_pc(pc0), .o_instr(instr0),
        .i_load_start(ld_start[0]), .i_byte(bdata0), .i_byte_valid(bvalid[0]),
        .o_byte_ready(rdy[0]), .o_busy(bsy[0]), .o_load_done(dn[0]),
        .o_full(fl[0]), .o_word_count(wc0)
    );

    imem_loadable #(.ADDR_W(2), .BIG_ENDIAN(1'b0), .HALT_WORD(32'hFFFF_FFFF)) u1 (
        .clk(clk), .reset(rst), .i_pc(pc1), .o_instr(instr1),
        .i_load_start(ld_start[1]), .i_byte(bdata1), .i_byte_valid(bvalid[1]),
        .o_byte_ready(rdy[1]), .o_busy(bsy[1]), .o_load_done(dn[1]),
        .o_full(fl[1]), .o_word_count(wc1)
    );

    function automatic int depth_of(int s);
        return (s == 0) ? 8 : 4;
    endfunction

    function automatic logic [31:0] get_instr(int s);
        return (s == 0) ? instr0 : instr1;
    endfunction

    function automatic logic [31:0] get_wc(int s);
        return (s == 0) ? {28'd0, wc0} : {29'd0, wc1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int s, input logic v, input logic [7:0] b);
        if (s == 0) begin
            bvalid[0] = v;
            bdata0    = b;
        end else begin
            bvalid[1] = v;
            bdata1    = b;
        end
    endtask

    task automatic set_pc(input int s, input logic [31:0] p);
        if (s == 0) pc0 = p;
        else        pc1 = p;
    endtask

    // Image model: clear to NOP, then pack groups of four bytes, stop at halt or when full.
    task automatic model_load(input int s);
        int depth = depth_of(s);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) exp_mem[s][i] = 32'h0;
        exp_wc[s]   = 0;
        exp_full[s] = 1'b0;
        exp_done[s] = 1'b0;
        exp_used[s] = 0;
        for (int i = 0; i + 3 < stream.size(); i += 4) begin
            if (s == 0) w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
            else        w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
            exp_mem[s][exp_wc[s]] = w;
            exp_wc[s]++;
            exp_used[s] = i + 4;
            if (w == 32'hFFFF_FFFF) begin
                exp_done[s] = 1'b1;
                break;
            end
            if (exp_wc[s] == depth) begin
                exp_done[s] = 1'b1;
                exp_full[s] = 1'b1;
                break;
            end
        end
    endtask

    // Start pulse (any byte already driven this cycle must be dropped), then clear timing.
    task automatic start_load(input int s, input string tag);
        ld_start[s] = 1'b1;
        step();
        ld_start[s] = 1'b0;
        set_byte(s, 1'b0, 8'h00);
        chk({tag, "_busy_start"}, {31'd0, bsy[s]}, 32'd1);
        chk({tag, "_ready_start"}, {31'd0, rdy[s]}, 32'd0);
        chk({tag, "_done_start"}, {31'd0, dn[s]}, 32'd0);
        chk({tag, "_wc_start"}, get_wc(s), 32'd0);
        chk({tag, "_nop_busy"}, get_instr(s), 32'h0);
        repeat (depth_of(s) - 1) step();
        chk({tag, "_ready_clear_end"}, {31'd0, rdy[s]}, 32'd0);
        step();
        chk({tag, "_ready_load"}, {31'd0, rdy[s]}, 32'd1);
        chk({tag, "_busy_load"}, {31'd0, bsy[s]}, 32'd1);
    endtask

    task automatic send(input int s, input int maxgap, input string tag);
        bit exp_rdy;
        for (int idx = 0; idx < stream.size(); idx++) begin
            repeat ($urandom_range(0, maxgap)) begin
                set_byte(s, 1'b0, 8'($urandom()));
                step();
            end
            set_byte(s, 1'b1, stream[idx]);
            exp_rdy = !(exp_done[s] && idx >= exp_used[s]);
            chk($sformatf("%s_ready_b%0d", tag, idx), {31'd0, rdy[s]}, {31'd0, exp_rdy});
            step();
        end
        set_byte(s, 1'b0, 8'h00);
    endtask

    task automatic check_image(input int s, input string tag);
        int aw = (s == 0) ? 3 : 2;
        logic [31:0] p;
        chk({tag, "_done"}, {31'd0, dn[s]}, {31'd0, exp_done[s]});
        chk({tag, "_busy"}, {31'd0, bsy[s]}, 32'd0);
        chk({tag, "_ready"}, {31'd0, rdy[s]}, 32'd0);
        chk({tag, "_full"}, {31'd0, fl[s]}, {31'd0, exp_full[s]});
        chk({tag, "_wc"}, get_wc(s), 32'(exp_wc[s]));
        for (int w = 0; w < depth_of(s); w++) begin
            p = $urandom();
            p = (p & ~((32'd1 << (aw + 2)) - 32'd1)) | (32'(w) << 2) | 32'($urandom_range(0, 3));
            set_pc(s, p);
            #1;
            chk($sformatf("%s_word%0d", tag, w), get_instr(s), exp_mem[s][w]);
        end
    endtask

    task automatic push_random_words(input int n);
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 254)));
    endtask

    initial begin
        logic [7:0] img [$];
        rst      = 1'b1;
        ld_start = 2'b00;
        bvalid   = 2'b00;
        bdata0   = 8'h00;
        bdata1   = 8'h00;
        pc0      = 32'h0;
        pc1      = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst%0d_busy", s), {31'd0, bsy[s]}, 32'd0);
            chk($sformatf("rst%0d_ready", s), {31'd0, rdy[s]}, 32'd0);
            chk($sformatf("rst%0d_done", s), {31'd0, dn[s]}, 32'd0);
            chk($sformatf("rst%0d_full", s), {31'd0, fl[s]}, 32'd0);
            chk($sformatf("rst%0d_wc", s), get_wc(s), 32'd0);
        end

        // Halt-only image: everything except word0 must read back as cleared NOPs.
        stream = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(0);
        start_load(0, "clr");
        send(0, 0, "clr");
        check_image(0, "clr");

        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(0);
        start_load(0, "be");
        send(0, 0, "be");
        check_image(0, "be");
        pc0 = 32'h0000_0004;
        #1;
        chk("be_pc4", instr0, 32'hFFFF_FFFF);

        stream = '{8'h05, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(1);
        start_load(1, "le");
        send(1, 0, "le");
        check_image(1, "le");
        pc1 = 32'h0;
        #1;
        chk("le_word0", instr1, 32'h2008_0005);

        // Four non-halt words fill the small instance; eight trailing bytes must be ignored.
        stream.delete();
        push_random_words(4);
        push_random_words(2);
        model_load(1);
        start_load(1, "full");
        send(1, 1, "full");
        check_image(1, "full");

        // Same random image with and without gaps on byte_valid.
        stream.delete();
        push_random_words(5);
        for (int i = 0; i < 4; i++) stream.push_back(8'hFF);
        img = stream;
        model_load(0);
        start_load(0, "nogap");
        send(0, 0, "nogap");
        check_image(0, "nogap");
        stream = img;
        start_load(0, "gap");
        send(0, 3, "gap");
        check_image(0, "gap");

        // Restart after one word plus two bytes; a byte coincident with the start is dropped.
        stream.delete();
        push_random_words(1);
        stream.push_back(8'h12);
        stream.push_back(8'h34);
        model_load(0);
        start_load(0, "rs1");
        send(0, 0, "rs1");
        set_byte(0, 1'b1, 8'hAB);
        stream.delete();
        push_random_words(3);
        for (int i = 0; i < 4; i++) stream.push_back(8'hFF);
        model_load(0);
        start_load(0, "rs2");
        send(0, 2, "rs2");
        check_image(0, "rs2");

        // Reset in the middle of a load: idle, no done flag, first word kept, rest cleared.
        stream.delete();
        push_random_words(1);
        stream.push_back(8'h55);
        model_load(0);
        start_load(0, "mr");
        send(0, 0, "mr");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_busy", {31'd0, bsy[0]}, 32'd0);
        chk("mr_done", {31'd0, dn[0]}, 32'd0);
        chk("mr_ready", {31'd0, rdy[0]}, 32'd0);
        chk("mr_wc", get_wc(0), 32'd0);
        pc0 = 32'h0;
        #1;
        chk("mr_word0", instr0, exp_mem[0][0]);
        pc0 = 32'h4;
        #1;
        chk("mr_word1", instr0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
